// File: rtl/mem_bus_router_if.sv
// mem_bus_router_if: bundles the CPU-side request/response signals and the
// per-channel slave bus of mem_bus_router.
//   slave  modport : view taken by the router itself
//   master modport : view taken by whatever surrounds the router (CPU side
//                    drives address/data/we/start, slaves drive s_q/s_ack)
// CPU side   : address, data, we, start -> busy, q, err, done
// Slave side : s_req, s_we, s_addr, s_d  -> s_q, s_ack (packed per channel)
interface mem_bus_router_if #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            data;
  logic                         we;
  logic                         start;
  logic                         busy;
  logic [DATA_W-1:0]            q;
  logic                         err;
  logic                         done;
  logic [NUM_SLAVES-1:0]        s_req;
  logic                         s_we;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_d;
  logic [NUM_SLAVES*DATA_W-1:0] s_q;
  logic [NUM_SLAVES-1:0]        s_ack;

  modport slave (
    input  address, data, we, start, s_q, s_ack,
    output busy, q, err, done, s_req, s_we, s_addr, s_d
  );

  modport master (
    output address, data, we, start, s_q, s_ack,
    input  busy, q, err, done, s_req, s_we, s_addr, s_d
  );
endinterface

// File: rtl/mem_bus_router.sv
// mem_bus_router: routes one CPU memory request at a time to one of
// NUM_SLAVES address windows [BASES[i], LIMITS[i]). Lowest index wins on
// overlapping windows. Channels flagged in FAST_MASK complete one cycle after
// the request; the others wait for s_ack, bounded by TIMEOUT cycles.
// Unmapped or timed-out accesses complete with q=0 and err=1.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : asynchronous active-low reset
//   bus   : mem_bus_router_if.slave (CPU request/response + slave channels)
module mem_bus_router #(
  parameter int                          ADDR_W     = 27,
  parameter int                          DATA_W     = 32,
  parameter int                          NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASES     =
    {27'hC00420, 27'hC00000, 27'h800000, 27'h0},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] LIMITS    =
    {27'hC02422, 27'hC00420, 27'hC00000, 27'h800000},
  parameter logic [NUM_SLAVES-1:0]       FAST_MASK  = 4'b1100,
  parameter int                          TIMEOUT    = 1023
) (
  input logic               clk,
  input logic               reset,
  mem_bus_router_if.slave   bus
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    FAST,
    UNMAPPED
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt;

  // Address decode of the live CPU address (only used in IDLE)
  logic               hit;
  logic [SEL_W-1:0]   hit_sel;
  logic [ADDR_W-1:0]  hit_base;
  logic               hit_fast;
  logic [NUM_SLAVES-1:0] hit_onehot;

  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_base = '0;
    hit_fast = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      // Ascending scan with a sticky hit flag gives lowest-index priority
      if (!hit &&
          bus.address >= BASES[i*ADDR_W +: ADDR_W] &&
          bus.address <  LIMITS[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        hit_sel  = SEL_W'(i);
        hit_base = BASES[i*ADDR_W +: ADDR_W];
        hit_fast = FAST_MASK[i];
      end
    end
    hit_onehot = NUM_SLAVES'(1) << hit_sel;
  end

  // Selected channel's return path
  logic [DATA_W-1:0] sel_q_data;
  logic              sel_ack;

  always_comb begin
    sel_q_data = bus.s_q[int'(sel_q)*DATA_W +: DATA_W];
    sel_ack    = bus.s_ack[sel_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sel_q      <= '0;
      cnt        <= '0;
      bus.busy   <= 1'b0;
      bus.q      <= '0;
      bus.err    <= 1'b0;
      bus.done   <= 1'b0;
      bus.s_req  <= '0;
      bus.s_we   <= 1'b0;
      bus.s_addr <= '0;
      bus.s_d    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy   <= 1'b1;
            bus.err    <= 1'b0;
            bus.s_we   <= bus.we;
            bus.s_d    <= bus.data;
            bus.s_addr <= bus.address - hit_base;
            sel_q      <= hit_sel;
            cnt        <= '0;
            if (!hit) begin
              state <= UNMAPPED;
            end else begin
              bus.s_req <= hit_onehot;
              state     <= hit_fast ? FAST : ACCESS;
            end
          end
        end

        FAST: begin
          bus.q     <= sel_q_data;
          bus.s_req <= '0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b1;
          state     <= IDLE;
        end

        ACCESS: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // Ack is tested first so an ack on the timeout edge still succeeds
          if (sel_ack) begin
            bus.q     <= sel_q_data;
            bus.s_req <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.q     <= '0;
            bus.err   <= 1'b1;
            bus.s_req <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= IDLE;
          end
        end

        UNMAPPED: begin
          bus.q    <= '0;
          bus.err  <= 1'b1;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Parametrised successor to the CPU memory unit's address decoder. Routes one CPU memory request at a time to one of NUM_SLAVES slave channels, each with its own base and limit address window.
- Per-channel handshake is either ack-based (SDRAM, SPI flash) or fixed single-cycle (VRAM, ROM, I/O registers).
- Adds behaviour the previous decoder lacked: registered request capture, overlap priority, per-transaction timeout, and an error flag for unmapped or timed-out accesses.
- Sits between the CPU bus and all memory and I/O slaves.

Parameters:
- ADDR_W, 27, CPU address width.
- DATA_W, 32, data width.
- NUM_SLAVES, 4, number of slave channels (1..16).
- BASES, packed NUM_SLAVES*ADDR_W, {27'hC00420,27'hC00000,27'h800000,27'h0}, inclusive window start per channel; channel 0 is the LSB slice.
- LIMITS, packed NUM_SLAVES*ADDR_W, {27'hC02422,27'hC00420,27'hC00000,27'h800000}, exclusive window end per channel.
- FAST_MASK, NUM_SLAVES bits, 4'b1100, bit i=1 means channel i completes without ack and its s_q is valid one cycle after s_req rises.
- TIMEOUT, 1023, maximum cycles to wait for s_ack (at least 1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  CPU address.
- data  in  DATA_W  CPU write data.
- we  in  1  write enable.
- start  in  1  request strobe; accepted only when busy=0.
- busy  out  1  transaction in progress.
- q  out  DATA_W  read data, held until the next completion.
- err  out  1  set when the last transaction was unmapped or timed out.
- done  out  1  one-cycle pulse on completion.
- s_req  out  NUM_SLAVES  one-hot level request, held until completion.
- s_we  out  1  latched we, valid while any s_req bit is high.
- s_addr  out  ADDR_W  latched address minus BASES[sel].
- s_d  out  DATA_W  latched data.
- s_q  in  NUM_SLAVES*DATA_W  per-channel read data.
- s_ack  in  NUM_SLAVES  per-channel completion (ack-based channels only).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, q=0, err=0, done=0, s_req=0, s_we=0, s_addr=0, s_d=0; timeout counter=0.
- Decode: channel i hits when BASES[i] <= address < LIMITS[i]. On overlap, the lowest index wins.
- States: IDLE, ACCESS, FAST, UNMAPPED.
- IDLE: on start=1 at an edge, latch we/data/address-offset, set busy=1, clear err, and go to:
  - FAST, if the selected channel is set in FAST_MASK; s_req[sel]=1.
  - ACCESS, if the selected channel is ack-based; s_req[sel]=1, counter=0.
  - UNMAPPED, if no channel hits; s_req stays 0.
- FAST: on the next edge, q<=s_q[sel] (reads and writes alike), s_req=0, busy=0, done=1, go to IDLE. Total latency is 2 edges.
- ACCESS: each edge, counter+1.
  - If s_ack[sel]=1: q<=s_q[sel], s_req=0, busy=0, done=1, go to IDLE.
  - Else if counter==TIMEOUT-1: q<=0, err=1, s_req=0, busy=0, done=1, go to IDLE.
  - If ack arrives on the timeout edge, ack wins and err=0.
- UNMAPPED: on the next edge, q<=0, err=1, busy=0, done=1, go to IDLE.
- While busy=1: start is ignored and latched fields do not change. Acks on unselected channels are ignored.
- After done, busy=0 and a new start may be accepted on the very next edge (back-to-back). done is 1 only in the cycle following completion.
- s_addr width truncation is done by the consuming slave; the router always outputs the full ADDR_W offset.
- Reset asserted mid-transaction: abort immediately, s_req=0, no done pulse. A late ack after reset release is ignored in IDLE.
- The counter saturates and never wraps within a transaction.

Test Plan:
- Read channel 0, address 0x000010: s_ack after 5 cycles with s_q0=0xDEADBEEF -> s_addr=0x10, s_req=0001 for 5 cycles, then q=0xDEADBEEF, err=0, done pulse, busy low.
- Fast read channel 2, address 0xC00005, s_q2=0x12345678 -> s_addr=0x5, busy high exactly 1 cycle after accept, q=0x12345678, no s_ack needed.
- Unmapped address 0xC02500 -> s_req stays 0, after 1 cycle err=1, q=0, done pulse.
- Ack-based channel never acks, TIMEOUT=8 -> s_req held 8 cycles, then dropped, err=1, q=0. Repeat with ack on cycle 8 -> err=0, q=s_q.
- Back-to-back: write 0xA5 to 0x800004 (acked cycle 1) followed by start on the next edge to 0xC00420 -> second request accepted immediately with s_addr=0. A start pulse during busy is ignored.
- Drive reset low during ACCESS wait -> s_req and busy drop asynchronously, no done. A stray s_ack after release leaves q, err and busy unchanged.
